boid_draw_scheduler: RTL and testbench

- Per-frame sequencer that renders every boid into the 640x480 palette-indexed framebuffer.
- On each frame_start it walks boid indices 0..NUM_BOIDS-1. For each boid it reads the position from the boid state memory, erases the pixel drawn last frame, and draws the new one.
- Sits between the boid processing units' position storage and the single framebuffer write port. It is the only master of that port.

---
 rtl/boid_video_pkg.sv | 37 +++
 rtl/pixel_addr_calc.sv | 15 +
 rtl/boid_draw_scheduler.sv | 157 +++++++++++++++
 tb/tb_boid_draw_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boid_video_pkg.sv
// Shared video constants, colour indices, scheduler state encoding and the
// framebuffer write payload used by the boid rendering path.
package boid_video_pkg;

  localparam int unsigned VIDEO_WIDTH           = 640;
  localparam int unsigned VIDEO_HEIGHT          = 480;
  localparam int unsigned PIXEL_COUNT           = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int unsigned PIXEL_ADDRESS_WIDTH   = 20;
  localparam int unsigned PALETTE_ADDRESS_WIDTH = 9;
  localparam int unsigned X_WIDTH               = 10;
  localparam int unsigned Y_WIDTH               = 9;

  localparam logic [PALETTE_ADDRESS_WIDTH-1:0] BOID_COLOR = 9'd255;
  localparam logic [PALETTE_ADDRESS_WIDTH-1:0] BG_COLOR   = 9'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_ERASE = 3'd3,
    ST_DRAW  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } draw_state_e;

  typedef struct packed {
    logic [PIXEL_ADDRESS_WIDTH-1:0]   addr;
    logic [PALETTE_ADDRESS_WIDTH-1:0] color;
  } fb_write_t;

  // True when the coordinate lies inside the visible frame.
  function automatic logic in_bounds(input logic [X_WIDTH-1:0] x,
                                     input logic [Y_WIDTH-1:0] y);
    return (32'(x) < VIDEO_WIDTH) && (32'(y) < VIDEO_HEIGHT);
  endfunction

endpackage

// File: rtl/pixel_addr_calc.sv
// Linear framebuffer address x + 640*y built from shifts and adds only.
module pixel_addr_calc
  import boid_video_pkg::*;
(
  input  logic [X_WIDTH-1:0]             x,
  input  logic [Y_WIDTH-1:0]             y,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] addr_c
);

  // 640*y = 512*y + 128*y
  assign addr_c = PIXEL_ADDRESS_WIDTH'(x)
                + (PIXEL_ADDRESS_WIDTH'(y) << 9)
                + (PIXEL_ADDRESS_WIDTH'(y) << 7);

endmodule

// File: rtl/boid_draw_scheduler.sv
// Per-frame sequencer: walks every boid, erases last frame's pixel and draws
// the new one through the single framebuffer write port.
module boid_draw_scheduler
  import boid_video_pkg::*;
#(
  parameter int unsigned NUM_BOIDS = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             frame_start,
  output logic                             boid_rd_en,
  output logic [$clog2(NUM_BOIDS)-1:0]     boid_idx,
  input  logic [X_WIDTH-1:0]               boid_x,
  input  logic [Y_WIDTH-1:0]               boid_y,
  output logic                             wr_valid,
  input  logic                             wr_ready,
  output logic [PIXEL_ADDRESS_WIDTH-1:0]   wr_addr,
  output logic [PALETTE_ADDRESS_WIDTH-1:0] wr_color,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             overrun
);

  localparam int unsigned IDX_W = $clog2(NUM_BOIDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOIDS - 1);

  draw_state_e state, state_next;
  logic [IDX_W-1:0]               idx, idx_next;
  logic [PIXEL_ADDRESS_WIDTH-1:0] new_addr, new_addr_next;
  logic                           on_screen, on_screen_next;
  logic [PIXEL_ADDRESS_WIDTH-1:0] old_addr [NUM_BOIDS];
  logic [NUM_BOIDS-1:0]           old_valid;

  logic [PIXEL_ADDRESS_WIDTH-1:0] calc_addr;
  logic                           calc_on;
  logic                           rd_en_next, wr_valid_next, busy_next, done_next, overrun_next;
  fb_write_t                      wr_next;

  pixel_addr_calc u_addr (
    .x      (boid_x),
    .y      (boid_y),
    .addr_c (calc_addr)
  );

  assign calc_on = in_bounds(boid_x, boid_y);

  // Next state plus the registered-output image of that next state.
  always_comb begin
    state_next     = state;
    idx_next       = idx;
    new_addr_next  = new_addr;
    on_screen_next = on_screen;
    wr_next        = '{addr: wr_addr, color: wr_color};
    overrun_next   = overrun | (frame_start && (state != ST_IDLE));

    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_next = ST_FETCH;
          idx_next   = '0;
        end
      end
      ST_FETCH: state_next = ST_LATCH;
      ST_LATCH: begin
        new_addr_next  = calc_addr;
        on_screen_next = calc_on;
        // An unchanged on-screen pixel is simply redrawn, never erased first.
        if (old_valid[idx] && !(calc_on && (calc_addr == old_addr[idx]))) begin
          state_next = ST_ERASE;
        end else if (calc_on) begin
          state_next = ST_DRAW;
        end else begin
          state_next = ST_NEXT;
        end
      end
      ST_ERASE: begin
        if (wr_ready) begin
          state_next = on_screen ? ST_DRAW : ST_NEXT;
        end
      end
      ST_DRAW: begin
        if (wr_ready) begin
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx == LAST_IDX) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_FETCH;
          idx_next   = idx + IDX_W'(1);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    rd_en_next    = (state_next == ST_FETCH);
    wr_valid_next = (state_next == ST_ERASE) || (state_next == ST_DRAW);
    busy_next     = state_next inside {ST_FETCH, ST_LATCH, ST_ERASE, ST_DRAW, ST_NEXT};
    done_next     = (state_next == ST_DONE);
    if (state_next == ST_ERASE) begin
      wr_next = '{addr: old_addr[idx_next], color: BG_COLOR};
    end else if (state_next == ST_DRAW) begin
      wr_next = '{addr: new_addr_next, color: BOID_COLOR};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      new_addr   <= '0;
      on_screen  <= 1'b0;
      boid_rd_en <= 1'b0;
      boid_idx   <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_color   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      new_addr   <= new_addr_next;
      on_screen  <= on_screen_next;
      boid_rd_en <= rd_en_next;
      boid_idx   <= idx_next;
      wr_valid   <= wr_valid_next;
      wr_addr    <= wr_next.addr;
      wr_color   <= wr_next.color;
      busy       <= busy_next;
      frame_done <= done_next;
      overrun    <= overrun_next;
    end
  end

  // Last-drawn pixel per boid; off-screen boids leave nothing to erase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      old_valid <= '0;
      for (int i = 0; i < NUM_BOIDS; i++) begin
        old_addr[i] <= '0;
      end
    end else begin
      if ((state == ST_DRAW) && wr_ready) begin
        old_addr[idx]  <= new_addr;
        old_valid[idx] <= 1'b1;
      end
      if ((state == ST_NEXT) && !on_screen) begin
        old_valid[idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boid_draw_scheduler.sv
// Bench for boid_draw_scheduler: a frame-level reference model predicts the
// write stream and frame length; directed frames pin the model to literals.
module tb_boid_draw_scheduler;
  import boid_video_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned IW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          boid_rd_en;
  logic [IW-1:0] boid_idx;
  logic [9:0]    boid_x;
  logic [8:0]    boid_y;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [19:0]   wr_addr;
  logic [8:0]    wr_color;
  logic          busy, frame_done, overrun;

  boid_draw_scheduler #(.NUM_BOIDS(NB)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .boid_rd_en(boid_rd_en), .boid_idx(boid_idx),
    .boid_x(boid_x), .boid_y(boid_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_color(wr_color),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #10 clock = ~clock;

  int unsigned pos_x [NB];
  int unsigned pos_y [NB];

  // Position memory: one-cycle read latency.
  always @(posedge clock) begin
    if (boid_rd_en) begin
      boid_x <= 10'(pos_x[boid_idx]);
      boid_y <= 9'(pos_y[boid_idx]);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model state
  int        m_old_addr [NB];
  bit        m_old_valid [NB];
  bit        m_overrun;
  bit        in_frame;
  int        exp_writes;
  fb_write_t exp_q[$];
  fb_write_t log_q[$];
  int        last_busy, last_max_hold, frames_done;

  task automatic model_frame();
    exp_q.delete();
    for (int i = 0; i < NB; i++) begin
      int a;
      bit on;
      a  = int'(pos_x[i]) + 640 * int'(pos_y[i]);
      on = (pos_x[i] < 640) && (pos_y[i] < 480);
      if (m_old_valid[i] && !(on && m_old_addr[i] == a))
        exp_q.push_back('{addr: 20'(m_old_addr[i]), color: BG_COLOR});
      if (on) begin
        exp_q.push_back('{addr: 20'(a), color: BOID_COLOR});
        m_old_addr[i]  = a;
        m_old_valid[i] = 1'b1;
      end else begin
        m_old_valid[i] = 1'b0;
      end
    end
    exp_writes = exp_q.size();
  endtask

  // Per-cycle compare against the model
  initial begin
    int busy_cyc, stalls, rd_cnt, hold, max_hold;
    bit pv, pxfer, xfer, done_now;
    logic [19:0] pa;
    logic [8:0]  pc;
    busy_cyc = 0; stalls = 0; rd_cnt = 0; hold = 0; max_hold = 0;
    pv = 0; pxfer = 0; pa = '0; pc = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        for (int i = 0; i < NB; i++) m_old_valid[i] = 1'b0;
        m_overrun = 0; in_frame = 0; pv = 0; pxfer = 0; hold = 0;
        continue;
      end
      xfer = wr_valid && wr_ready;
      chk("overrun", 32'(overrun), 32'(m_overrun));
      if (pv && !pxfer) begin
        chk("valid_held", 32'(wr_valid), 1);
        if (wr_valid) begin
          chk("addr_stable", 32'(wr_addr), 32'(pa));
          chk("color_stable", 32'(wr_color), 32'(pc));
        end
      end
      if (pxfer && pc == BOID_COLOR) chk("valid_drop_after_draw", 32'(wr_valid), 0);
      if (wr_valid) hold++;
      if (wr_valid && !wr_ready) stalls++;
      if (xfer) begin
        if (hold > max_hold) max_hold = hold;
        hold = 0;
        log_q.push_back('{addr: wr_addr, color: wr_color});
        chk("write_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          fb_write_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_color", 32'(wr_color), 32'(e.color));
        end
      end
      done_now = 0;
      if (in_frame) begin
        if (boid_rd_en) begin
          chk("rd_idx", 32'(boid_idx), 32'(rd_cnt));
          rd_cnt++;
        end
        if (frame_done) begin
          done_now = 1;
          chk("busy_at_done", 32'(busy), 0);
          chk("queue_drained", 32'(exp_q.size()), 0);
          chk("rd_count", 32'(rd_cnt), NB);
          chk("frame_cycles", 32'(busy_cyc), 32'(3 * NB + exp_writes + stalls));
          last_busy = busy_cyc;
          last_max_hold = max_hold;
          frames_done++;
          in_frame = 0;
        end else begin
          chk("busy", 32'(busy), 1);
          busy_cyc++;
        end
      end else begin
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(frame_done), 0);
        chk("idle_rd", 32'(boid_rd_en), 0);
        chk("idle_valid", 32'(wr_valid), 0);
      end
      if (frame_start) begin
        if (in_frame || done_now) m_overrun = 1;
        else begin
          model_frame();
          in_frame = 1; busy_cyc = 0; stalls = 0; rd_cnt = 0; max_hold = 0; hold = 0;
        end
      end
      pv = wr_valid; pxfer = xfer; pa = wr_addr; pc = wr_color;
    end
  end

  // wr_ready driver: 0 always-ready, 1 random, 2 stall first draw, 3 never ready
  int ready_mode = 0;
  int stall_left = 0;
  initial begin
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        1: wr_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (wr_valid && wr_color == BOID_COLOR && stall_left > 0) begin
            wr_ready = 1'b0;
            stall_left--;
          end else wr_ready = 1'b1;
        end
        3: wr_ready = 1'b0;
        default: wr_ready = 1'b1;
      endcase
    end
  end

  task automatic set_boid(input int i, input int unsigned x, input int unsigned y);
    pos_x[i] = x;
    pos_y[i] = y;
  endtask

  // Start a frame; optionally pulse frame_start mid-frame or on the done cycle.
  task automatic run_frame(input int pulse_at, input bit pulse_done);
    int c;
    bit seen;
    log_q.delete();
    @(posedge clock); #1 frame_start = 1'b1;
    @(posedge clock); #1 frame_start = 1'b0;
    c = 0; seen = 0;
    while (!seen && c < 3000) begin
      if (frame_done) begin
        seen = 1;
        if (pulse_done) frame_start = 1'b1;
      end else if (c == pulse_at && busy) frame_start = 1'b1;
      @(posedge clock); #1 frame_start = 1'b0;
      c++;
    end
    chk("frame_timeout", 32'(seen), 1);
  endtask

  task automatic pin_write(input string name, input int k, input int addr, input int color);
    logic [31:0] a, cl;
    a = '1; cl = '1;
    if (k < log_q.size()) begin
      a  = 32'(log_q[k].addr);
      cl = 32'(log_q[k].color);
    end
    chk({name, "_addr"}, a, 32'(addr));
    chk({name, "_color"}, cl, 32'(color));
  endtask

  task automatic do_reset();
    @(posedge clock); #3 reset = 1'b1;
    @(negedge clock);
    @(posedge clock); #1 reset = 1'b0;
  endtask

  initial begin
    int n0, fd, guard;
    bit hit;
    for (int i = 0; i < NB; i++) set_boid(i, 700, 0);
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(wr_valid), 0);
    chk("rst_rd_en", 32'(boid_rd_en), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_idx", 32'(boid_idx), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_color", 32'(wr_color), 0);
    @(posedge clock); #1 reset = 1'b0;

    set_boid(0, 100, 100); set_boid(1, 0, 0);
    run_frame(-1, 0);
    chk("f1_count", 32'(log_q.size()), 2);
    pin_write("f1_w0", 0, 64100, 255);
    pin_write("f1_w1", 1, 0, 255);
    chk("f1_busy_cycles", 32'(last_busy), 14);

    set_boid(0, 101, 100);
    run_frame(-1, 0);
    chk("f2_count", 32'(log_q.size()), 3);
    pin_write("f2_w0", 0, 64100, 0);
    pin_write("f2_w1", 1, 64101, 255);
    pin_write("f2_w2", 2, 0, 255);
    chk("f2_busy_cycles", 32'(last_busy), 15);

    set_boid(0, 639, 479);
    run_frame(-1, 0);
    pin_write("f3_w1", 1, 307199, 255);

    set_boid(0, 640, 10);
    run_frame(-1, 0);
    chk("f4_count", 32'(log_q.size()), 2);
    pin_write("f4_w0", 0, 307199, 0);
    pin_write("f4_w1", 1, 0, 255);

    set_boid(0, 5, 5);
    run_frame(-1, 0);
    chk("f5_count", 32'(log_q.size()), 2);
    pin_write("f5_w0", 0, 3205, 255);

    set_boid(0, 6, 5);
    ready_mode = 2; stall_left = 3;
    run_frame(-1, 0);
    ready_mode = 0;
    chk("bp_hold", 32'(last_max_hold), 4);
    chk("bp_busy_cycles", 32'(last_busy), 18);
    pin_write("bp_w1", 1, 3206, 255);

    fd = frames_done;
    run_frame(5, 0);
    chk("ovr_set", 32'(overrun), 1);
    repeat (10) @(negedge clock);
    chk("ovr_no_second_frame", 32'(frames_done), 32'(fd + 1));
    chk("ovr_idle_busy", 32'(busy), 0);
    chk("ovr_sticky", 32'(overrun), 1);

    do_reset();
    chk("clr_overrun", 32'(overrun), 0);
    run_frame(-1, 1);
    repeat (3) @(negedge clock);
    chk("done_cycle_overrun", 32'(overrun), 1);

    // Reset while an erase is held off by back-pressure
    set_boid(0, 7, 5);
    ready_mode = 3;
    @(posedge clock); #1 frame_start = 1'b1;
    @(posedge clock); #1 frame_start = 1'b0;
    hit = 0; guard = 0;
    while (!hit && guard < 200) begin
      @(negedge clock);
      hit = wr_valid && (wr_color == BG_COLOR);
      guard++;
    end
    chk("erase_reached", 32'(hit), 1);
    #3 reset = 1'b1;
    #1;
    chk("async_valid", 32'(wr_valid), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_rd_en", 32'(boid_rd_en), 0);
    chk("async_done", 32'(frame_done), 0);
    chk("async_overrun", 32'(overrun), 0);
    chk("async_idx", 32'(boid_idx), 0);
    chk("async_addr", 32'(wr_addr), 0);
    chk("async_color", 32'(wr_color), 0);
    @(negedge clock);
    @(posedge clock); #1 reset = 1'b0;
    ready_mode = 0;

    set_boid(0, 8, 5);
    run_frame(-1, 0);
    n0 = 0;
    foreach (log_q[k]) if (log_q[k].color == BG_COLOR) n0++;
    chk("post_reset_erases", 32'(n0), 0);
    pin_write("post_reset_w0", 0, 3208, 255);

    ready_mode = 1;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < NB; i++) begin
        case ($urandom_range(0, 3))
          0: ;
          1: set_boid(i, $urandom_range(640, 1023), $urandom_range(0, 511));
          default: set_boid(i, $urandom_range(0, 639), $urandom_range(0, 479));
        endcase
      end
      run_frame(($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 20)) : -1, 1'b0);
    end
    ready_mode = 0;
    repeat (4) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
